// File: rtl/ps2_rx.sv
// ps2_rx: receiver for the two-wire keyboard-style serial link.
// Synchronises and deglitches the raw line clock and data, deframes
// start / 8 data bits LSB first / odd parity / stop, and presents each
// good byte on a one-entry valid/ready output register. Parity errors,
// framing errors (bad stop bit or stalled line clock) and overruns are
// reported as mutually exclusive one-cycle pulses.
module ps2_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   line_clk;
    logic                   line_dat;

    logic                   filt_clk;
    logic [FW-1:0]          filt_cnt;
    logic                   fall;

    state_t                 state;
    logic [7:0]             shift;
    logic [2:0]             bit_cnt;
    logic                   par_bit;
    logic [TW-1:0]          timer;
    logic                   timed_out;

    assign line_clk  = clk_sync[SYNC_STAGES-1];
    assign line_dat  = dat_sync[SYNC_STAGES-1];
    assign timed_out = (timer == TIMER_MAX);

    // Bring both asynchronous lines into the system clock domain; idle level is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
        end
    end

    // Follow the line clock only after it holds a new level for FILTER_LEN cycles; flag the 1->0 step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (line_clk != filt_clk) begin
                if (filt_cnt == FILT_LAST) begin
                    filt_clk <= line_clk;
                    filt_cnt <= '0;
                    fall     <= ~line_clk;
                end else begin
                    filt_cnt <= filt_cnt + FW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // Deframing FSM, stall timer, output register and error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            timer      <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (state == IDLE || fall) begin
                timer <= '0;
            end else if (!timed_out) begin
                timer <= timer + TW'(1);
            end

            if (state != IDLE && !fall && timed_out) begin
                frame_err <= 1'b1;
                state     <= IDLE;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (fall && !line_dat) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    DATA: begin
                        if (fall) begin
                            shift[bit_cnt] <= line_dat;
                            bit_cnt        <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= PARITY;
                            end
                        end
                    end
                    PARITY: begin
                        if (fall) begin
                            par_bit <= line_dat;
                            state   <= STOP;
                        end
                    end
                    STOP: begin
                        if (fall) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!line_dat) begin
                                frame_err <= 1'b1;
                            end else if (!(^{shift, par_bit})) begin
                                parity_err <= 1'b1;
                            end else if (!out_valid || out_ready) begin
                                out_data  <= shift;
                                out_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: self-checking bench for ps2_rx. Drives line frames at an
// 80-cycle bit period, checks a table of directed frames, hand-written
// overrun / timeout / glitch / reset sequences, and randomized frames
// against a frame-level reference model of the one-entry output buffer.
`timescale 1ns/1ps
module tb_ps2_rx;

    localparam int S        = 2;
    localparam int F        = 4;
    localparam int T        = 2000;
    localparam int BIT_HALF = 40;
    localparam int LEAD     = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    ps2_rx #(
        .SYNC_STAGES   (S),
        .FILTER_LEN    (F),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    // 1 MHz system clock.
    always #500 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       ready;
        int         exp_par;
        int         exp_frm;
        int         exp_valid;
        logic [7:0] exp_data;
        int         exp_acc;
    } vec_t;

    vec_t       vecs[7];
    int         tests = 0;
    int         fails = 0;
    int         par_seen = 0;
    int         frm_seen = 0;
    int         ovr_seen = 0;
    int         excl_viol = 0;
    int         cyc = 0;
    int         last_fall_cyc = 0;
    logic [7:0] acc_q[$];

    // Free-running cycle count used to time the stall abort.
    always @(posedge clk) cyc <= cyc + 1;

    // Observe the DUT once per cycle, away from the active edge: log accepted bytes and pulses.
    always begin
        @(negedge clk);
        #1;
        if (out_valid && out_ready) acc_q.push_back(out_data);
        par_seen += int'(parity_err);
        frm_seen += int'(frame_err);
        ovr_seen += int'(overrun);
        if (int'(parity_err) + int'(frame_err) + int'(overrun) > 1) excl_viol++;
    end

    // Watchdog so the run always ends.
    initial begin
        #(150_000_000);
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Send nbits of a frame; gmask marks bits that get a 2-cycle low glitch in their high phase;
    // ready_pulse raises out_ready for exactly the cycle the stop bit is acted on.
    task automatic applyStimulus(input logic [7:0] d, input logic p, input logic s,
                                 input int nbits, input logic [10:0] gmask, input bit ready_pulse);
        logic [10:0] fr;
        fr = {s, p, d, 1'b0};
        @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = fr[i];
            if (gmask[i]) begin
                idle(5);
                ps2_clk = 1'b0;
                idle(2);
                ps2_clk = 1'b1;
                idle(LEAD - 7);
            end else begin
                idle(LEAD);
            end
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            if (ready_pulse && i == 10) begin
                idle(S + F);
                out_ready = 1'b1;
                idle(1);
                out_ready = 1'b0;
                idle(BIT_HALF - S - F - 1);
            end else begin
                idle(BIT_HALF);
            end
            ps2_clk = 1'b1;
            idle(BIT_HALF - LEAD);
        end
        ps2_dat = 1'b1;
    endtask

    task automatic glitchIdle();
        ps2_clk = 1'b0;
        idle(2);
        ps2_clk = 1'b1;
        idle(10);
    endtask

    task automatic drain();
        if (out_valid) begin
            out_ready = 1'b1;
            idle(1);
            out_ready = 1'b0;
        end
        idle(2);
    endtask

    initial begin
        int p0, f0, o0, a0;
        int got, elapsed;
        bit         slot_full;
        logic [7:0] slot_data;
        logic [7:0] exp_acc[$];

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 0, 0, 1, 8'hA5, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 0, 0, 0, 8'h00, 1};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 0, 0, 0, 8'h00, 1};
        vecs[3] = '{8'h01, 1'b0, 1'b1, 1'b1, 0, 0, 0, 8'h00, 1};
        // 0x3C has four ones, so parity 0 is the wrong bit.
        vecs[4] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1, 0, 0, 8'h00, 0};
        vecs[5] = '{8'h3C, 1'b1, 1'b0, 1'b0, 0, 1, 0, 8'h00, 0};
        // Bad stop bit wins over bad parity.
        vecs[6] = '{8'h96, 1'b0, 1'b0, 1'b0, 0, 1, 0, 8'h00, 0};

        reset     = 1'b1;
        ps2_clk   = 1'b1;
        ps2_dat   = 1'b1;
        out_ready = 1'b0;
        idle(3);
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset out_data", int'(out_data), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset parity_err", int'(parity_err), 0);
        checkOutput("reset frame_err", int'(frame_err), 0);
        checkOutput("reset overrun", int'(overrun), 0);
        reset = 1'b0;
        idle(5);

        for (int i = 0; i < 7; i++) begin
            drain();
            p0 = par_seen; f0 = frm_seen; o0 = ovr_seen; a0 = acc_q.size();
            out_ready = vecs[i].ready;
            applyStimulus(vecs[i].data, vecs[i].par, vecs[i].stop, 11, 11'd0, 1'b0);
            idle(20);
            checkOutput($sformatf("vec%0d parity_err", i), par_seen - p0, vecs[i].exp_par);
            checkOutput($sformatf("vec%0d frame_err", i), frm_seen - f0, vecs[i].exp_frm);
            checkOutput($sformatf("vec%0d overrun", i), ovr_seen - o0, 0);
            checkOutput($sformatf("vec%0d busy", i), int'(busy), 0);
            checkOutput($sformatf("vec%0d out_valid", i), int'(out_valid), vecs[i].exp_valid);
            if (vecs[i].exp_valid != 0)
                checkOutput($sformatf("vec%0d out_data", i), int'(out_data), int'(vecs[i].exp_data));
            checkOutput($sformatf("vec%0d accepts", i), acc_q.size() - a0, vecs[i].exp_acc);
            if (vecs[i].exp_acc != 0 && acc_q.size() > a0)
                checkOutput($sformatf("vec%0d accepted byte", i), int'(acc_q[a0]), int'(vecs[i].data));
            out_ready = 1'b0;
        end

        // Overrun: second good byte arrives while the first is still held.
        drain();
        p0 = par_seen; f0 = frm_seen; o0 = ovr_seen;
        applyStimulus(8'h12, 1'b1, 1'b1, 11, 11'd0, 1'b0);
        applyStimulus(8'h34, 1'b0, 1'b1, 11, 11'd0, 1'b0);
        idle(20);
        checkOutput("overrun out_data kept", int'(out_data), 'h12);
        checkOutput("overrun out_valid", int'(out_valid), 1);
        checkOutput("overrun pulses", ovr_seen - o0, 1);
        checkOutput("overrun other errors", (par_seen - p0) + (frm_seen - f0), 0);

        // Accept and load in the same cycle.
        drain();
        applyStimulus(8'h12, 1'b1, 1'b1, 11, 11'd0, 1'b0);
        a0 = acc_q.size(); o0 = ovr_seen;
        applyStimulus(8'h34, 1'b0, 1'b1, 11, 11'd0, 1'b1);
        idle(20);
        checkOutput("simul out_valid", int'(out_valid), 1);
        checkOutput("simul out_data", int'(out_data), 'h34);
        checkOutput("simul overrun", ovr_seen - o0, 0);
        checkOutput("simul accepts", acc_q.size() - a0, 1);
        if (acc_q.size() > a0) checkOutput("simul accepted byte", int'(acc_q[a0]), 'h12);

        // Stalled line clock after four data bits.
        drain();
        f0 = frm_seen; p0 = par_seen;
        applyStimulus(8'hE7, 1'b1, 1'b1, 5, 11'd0, 1'b0);
        checkOutput("stall busy mid-frame", int'(busy), 1);
        got = 0; elapsed = 0;
        for (int k = 0; k < T + 100 && got == 0; k++) begin
            @(negedge clk);
            #1;
            if (frame_err) begin
                got = 1;
                elapsed = cyc - last_fall_cyc;
            end
        end
        checkOutput("stall frame_err seen", got, 1);
        if (got != 0)
            checkOutput($sformatf("stall latency %0d in window", elapsed),
                        int'(elapsed >= T && elapsed <= T + S + F + 6), 1);
        idle(3);
        checkOutput("stall busy after abort", int'(busy), 0);
        checkOutput("stall frame_err count", frm_seen - f0, 1);
        checkOutput("stall out_valid", int'(out_valid), 0);
        f0 = frm_seen;
        applyStimulus(8'h5A, 1'b1, 1'b1, 11, 11'd0, 1'b0);
        idle(20);
        checkOutput("post-stall out_data", int'(out_data), 'h5A);
        checkOutput("post-stall out_valid", int'(out_valid), 1);
        checkOutput("post-stall errors", (frm_seen - f0) + (par_seen - p0), 0);

        // Short low glitches on the line clock, idle and mid-frame.
        drain();
        f0 = frm_seen; p0 = par_seen;
        for (int g = 0; g < 3; g++) glitchIdle();
        checkOutput("glitch idle busy", int'(busy), 0);
        applyStimulus(8'hC3, 1'b1, 1'b1, 11, 11'b001_0010_1000, 1'b0);
        idle(20);
        checkOutput("glitch out_data", int'(out_data), 'hC3);
        checkOutput("glitch out_valid", int'(out_valid), 1);
        checkOutput("glitch errors", (frm_seen - f0) + (par_seen - p0), 0);

        // Reset mid-frame while a byte is held.
        applyStimulus(8'h77, 1'b1, 1'b1, 4, 11'd0, 1'b0);
        checkOutput("midreset busy before", int'(busy), 1);
        reset = 1'b1;
        idle(2);
        checkOutput("midreset out_valid", int'(out_valid), 0);
        checkOutput("midreset out_data", int'(out_data), 0);
        checkOutput("midreset busy", int'(busy), 0);
        checkOutput("midreset pulses", int'(parity_err) + int'(frame_err) + int'(overrun), 0);
        reset = 1'b0;
        idle(10);
        f0 = frm_seen; p0 = par_seen;
        applyStimulus(8'h12, 1'b1, 1'b1, 11, 11'd0, 1'b0);
        idle(20);
        checkOutput("post-reset out_data", int'(out_data), 'h12);
        checkOutput("post-reset errors", (frm_seen - f0) + (par_seen - p0), 0);

        // Randomized frames against a frame-level model of the output buffer.
        drain();
        slot_full = 1'b0;
        slot_data = 8'h00;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic       p, s, r;
            int         ep, ef, eo;
            d = 8'($urandom);
            p = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
            if ($urandom_range(3) == 0) p = ~p;
            s = ($urandom_range(7) == 0) ? 1'b0 : 1'b1;
            r = 1'($urandom_range(1));
            exp_acc.delete();
            ep = 0; ef = 0; eo = 0;
            if (r && slot_full) begin
                exp_acc.push_back(slot_data);
                slot_full = 1'b0;
            end
            if (!s) ef = 1;
            else if (($countones(d) + int'(p)) % 2 == 0) ep = 1;
            else if (r) exp_acc.push_back(d);
            else if (slot_full) eo = 1;
            else begin
                slot_full = 1'b1;
                slot_data = d;
            end

            p0 = par_seen; f0 = frm_seen; o0 = ovr_seen; a0 = acc_q.size();
            out_ready = r;
            idle(2);
            applyStimulus(d, p, s, 11, 11'd0, 1'b0);
            idle(20);
            checkOutput($sformatf("rnd%0d parity_err", n), par_seen - p0, ep);
            checkOutput($sformatf("rnd%0d frame_err", n), frm_seen - f0, ef);
            checkOutput($sformatf("rnd%0d overrun", n), ovr_seen - o0, eo);
            checkOutput($sformatf("rnd%0d out_valid", n), int'(out_valid), int'(slot_full));
            if (slot_full) checkOutput($sformatf("rnd%0d out_data", n), int'(out_data), int'(slot_data));
            checkOutput($sformatf("rnd%0d accepts", n), acc_q.size() - a0, exp_acc.size());
            for (int k = 0; k < exp_acc.size() && a0 + k < acc_q.size(); k++)
                checkOutput($sformatf("rnd%0d accepted byte %0d", n, k),
                            int'(acc_q[a0 + k]), int'(exp_acc[k]));
            checkOutput($sformatf("rnd%0d busy", n), int'(busy), 0);
            out_ready = 1'b0;
        end

        checkOutput("pulse exclusivity violations", excl_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
